// File: rtl/riscv_pkg.sv
// Shared RISC-V encodings for the load/store unit: funct3 access codes and
// FSM/access-size enums, plus helpers to decode size and detect misalignment.
package riscv_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_e;

    // Unlisted funct3 codes fall back to a full-word access.
    function automatic lsu_size_e access_size(input logic is_store, input logic [2:0] funct3);
        lsu_size_e sz;
        sz = SZ_WORD;
        if (is_store) begin
            if (funct3 == F3_SB)      sz = SZ_BYTE;
            else if (funct3 == F3_SH) sz = SZ_HALF;
        end else begin
            if (funct3 == F3_LB || funct3 == F3_LBU)      sz = SZ_BYTE;
            else if (funct3 == F3_LH || funct3 == F3_LHU) sz = SZ_HALF;
        end
        return sz;
    endfunction

    function automatic logic is_misaligned(input lsu_size_e sz, input logic [1:0] addr_lo);
        return ((sz == SZ_HALF) && addr_lo[0]) || ((sz == SZ_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store byte enables / replicated write data, and
// load lane extraction with sign or zero extension.
module lsu_align
    import riscv_pkg::*;
(
    input  lsu_size_e   size,
    input  logic        load_unsigned,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [1:0]  off;
    logic [31:0] shifted;

    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        off   = 2'b00;
        wstrb = 4'hF;
        wdata = store_data;
        case (size)
            SZ_BYTE: begin
                off   = addr_lo;
                wstrb = 4'b0001 << off;
                wdata = {4{store_data[7:0]}};
            end
            SZ_HALF: begin
                off   = {addr_lo[1], 1'b0};
                wstrb = 4'b0011 << off;
                wdata = {2{store_data[15:0]}};
            end
            default: ;
        endcase

        shifted   = load_word >> {off, 3'b000};
        load_data = shifted;
        case (size)
            SZ_BYTE: load_data = {{24{~load_unsigned & shifted[7]}}, shifted[7:0]};
            SZ_HALF: load_data = {{16{~load_unsigned & shifted[15]}}, shifted[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: one req/ack bus transaction per load/store, load formatting and
// ALU pass-through. Optional misaligned-access trap: `define LSU_MISALIGN_TRAP_EN.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            is_load,
    input  logic            is_store,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_in,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_wstrb,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_we,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_data,
    output logic            out_err,
    output logic            out_misalign
);

    localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    lsu_state_e      state_q, state_d;
    logic            is_load_q, is_load_d;
    logic            is_store_q, is_store_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] rs2_q, rs2_d;
    logic [4:0]      rd_q, rd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            out_valid_q, out_valid_d;
    logic            out_we_q, out_we_d;
    logic [XLEN-1:0] out_data_q, out_data_d;
    logic            out_err_q, out_err_d;
    logic            out_misalign_q, out_misalign_d;

    lsu_size_e   size_q;
    logic [3:0]  lane_wstrb;
    logic [31:0] lane_wdata;
    logic [31:0] lane_load;

    assign size_q = access_size(is_store_q, funct3_q);

    lsu_align u_align (
        .size          (size_q),
        .load_unsigned (funct3_q[2]),
        .addr_lo       (addr_q[1:0]),
        .store_data    (rs2_q),
        .load_word     (mem_rdata),
        .wstrb         (lane_wstrb),
        .wdata         (lane_wdata),
        .load_data     (lane_load)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    logic in_misaligned;
    assign in_misaligned = is_misaligned(access_size(is_store, funct3), alu_result[1:0]);
`endif

    always_comb begin
        state_d        = state_q;
        is_load_d      = is_load_q;
        is_store_d     = is_store_q;
        funct3_d       = funct3_q;
        addr_d         = addr_q;
        rs2_d          = rs2_q;
        rd_d           = rd_q;
        cnt_d          = cnt_q;
        out_valid_d    = out_valid_q;
        out_we_d       = out_we_q;
        out_data_d     = out_data_q;
        out_err_d      = out_err_q;
        out_misalign_d = out_misalign_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    is_load_d      = is_load;
                    is_store_d     = is_store;
                    funct3_d       = funct3;
                    addr_d         = alu_result;
                    rs2_d          = rs2_data;
                    rd_d           = rd_in;
                    cnt_d          = '0;
                    out_err_d      = 1'b0;
                    out_misalign_d = 1'b0;
                    if (!(is_load || is_store)) begin
                        out_data_d  = alu_result;
                        out_we_d    = (rd_in != 5'd0);
                        out_valid_d = 1'b1;
                        state_d     = ST_RESP;
                    end else begin
`ifdef LSU_MISALIGN_TRAP_EN
                        if (in_misaligned) begin
                            out_data_d     = alu_result;
                            out_we_d       = 1'b0;
                            out_misalign_d = 1'b1;
                            out_valid_d    = 1'b1;
                            state_d        = ST_RESP;
                        end else begin
                            state_d = ST_REQ;
                        end
`else
                        state_d = ST_REQ;
`endif
                    end
                end
            end
            ST_REQ: begin
                // An ack on the expiry cycle still completes normally.
                if (mem_ack) begin
                    out_data_d  = is_load_q ? lane_load : addr_q;
                    out_we_d    = is_load_q && (rd_q != 5'd0);
                    out_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else if ((MEM_TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
                    out_data_d  = addr_q;
                    out_we_d    = 1'b0;
                    out_err_d   = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RESP: begin
                if (out_ready) begin
                    out_valid_d    = 1'b0;
                    out_we_d       = 1'b0;
                    out_err_d      = 1'b0;
                    out_misalign_d = 1'b0;
                    state_d        = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state updates use <= so every flop samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            is_load_q      <= 1'b0;
            is_store_q     <= 1'b0;
            funct3_q       <= 3'b000;
            addr_q         <= '0;
            rs2_q          <= '0;
            rd_q           <= 5'd0;
            cnt_q          <= '0;
            out_valid_q    <= 1'b0;
            out_we_q       <= 1'b0;
            out_data_q     <= '0;
            out_err_q      <= 1'b0;
            out_misalign_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            is_load_q      <= is_load_d;
            is_store_q     <= is_store_d;
            funct3_q       <= funct3_d;
            addr_q         <= addr_d;
            rs2_q          <= rs2_d;
            rd_q           <= rd_d;
            cnt_q          <= cnt_d;
            out_valid_q    <= out_valid_d;
            out_we_q       <= out_we_d;
            out_data_q     <= out_data_d;
            out_err_q      <= out_err_d;
            out_misalign_q <= out_misalign_d;
        end
    end

    // Bus outputs decode straight from state so reset drops mem_req without waiting for a clock.
    assign in_ready     = (state_q == ST_IDLE);
    assign mem_req      = (state_q == ST_REQ);
    assign mem_we       = mem_req & is_store_q;
    assign mem_addr     = {addr_q[XLEN-1:2], 2'b00};
    assign mem_wdata    = is_store_q ? lane_wdata : '0;
    assign mem_wstrb    = mem_we ? lane_wstrb : 4'h0;
    assign out_valid    = out_valid_q;
    assign out_we       = out_we_q;
    assign out_rd       = rd_q;
    assign out_data     = out_data_q;
    assign out_err      = out_err_q;
    assign out_misalign = out_misalign_q;

endmodule
